// File: rtl/sort_checker.sv
// sort_checker
//   Streams an unsorted block and a claimed-sorted block side by side and
//   judges whether the second is a correctly ordered permutation of the first.
//   Ordering is checked beat by beat against the previous sorted element.
//   Permutation is checked with two multiset signatures (sum and xor) per stream.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin a new block (honoured only in IDLE)
//   in_valid   : beat carries one orig/sort element pair
//   in_ready   : checker accepts a beat this cycle (RUN only)
//   orig_data  : unsorted source element k
//   sort_data  : element k of the claimed sorted block
//   done       : one-cycle pulse, verdict valid
//   pass       : verdict, held until the next start
//   err_order  : sticky ordering violation flag
//   err_perm   : signature mismatch between the two streams
//   err_idx    : index of the first ordering violation (0 if none)
module sort_checker #(
  parameter int N = 100,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] orig_data,
  input  logic [W-1:0] sort_data,
  output logic         done,
  output logic         pass,
  output logic         err_order,
  output logic         err_perm,
  output logic [7:0]   err_idx
);

  localparam int SW = W + 7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] K_LAST = 7'(N - 1);

  logic [1:0]    r_state;
  logic [6:0]    r_k;
  logic [W-1:0]  r_prev;
  logic [SW-1:0] r_sum_o;
  logic [SW-1:0] r_sum_s;
  logic [W-1:0]  r_xor_o;
  logic [W-1:0]  r_xor_s;
  logic          r_err_order;
  logic          r_err_perm;
  logic [7:0]    r_err_idx;
  logic          r_pass;

  logic          w_accept;
  logic          w_last;
  logic          w_viol;
  logic          w_err_order_nx;
  logic          w_err_perm_nx;
  logic [SW-1:0] w_sum_o_nx;
  logic [SW-1:0] w_sum_s_nx;
  logic [W-1:0]  w_xor_o_nx;
  logic [W-1:0]  w_xor_s_nx;

  // Signatures differ if either the sums or the xors disagree.
  function automatic logic perm_mismatch(
    input logic [SW-1:0] sum_a,
    input logic [SW-1:0] sum_b,
    input logic [W-1:0]  xor_a,
    input logic [W-1:0]  xor_b
  );
    return (sum_a != sum_b) || (xor_a != xor_b);
  endfunction

  always_comb begin
    w_accept       = (r_state == S_RUN) && in_valid;
    w_last         = w_accept && (r_k == K_LAST);
    // Beat 0 has no predecessor in this block; unsigned full-width compare.
    w_viol         = w_accept && (r_k != 7'd0) && (sort_data < r_prev);
    w_err_order_nx = r_err_order | w_viol;
    w_sum_o_nx     = r_sum_o + {7'd0, orig_data};
    w_sum_s_nx     = r_sum_s + {7'd0, sort_data};
    w_xor_o_nx     = r_xor_o ^ orig_data;
    w_xor_s_nx     = r_xor_s ^ sort_data;
    // Judged on the post-beat signatures so the verdict costs no extra cycle.
    w_err_perm_nx  = perm_mismatch(w_sum_o_nx, w_sum_s_nx, w_xor_o_nx, w_xor_s_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_prev      <= '0;
      r_sum_o     <= '0;
      r_sum_s     <= '0;
      r_xor_o     <= '0;
      r_xor_s     <= '0;
      r_err_order <= 1'b0;
      r_err_perm  <= 1'b0;
      r_err_idx   <= '0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_k         <= '0;
            r_prev      <= '0;
            r_sum_o     <= '0;
            r_sum_s     <= '0;
            r_xor_o     <= '0;
            r_xor_s     <= '0;
            r_err_order <= 1'b0;
            r_err_perm  <= 1'b0;
            r_err_idx   <= '0;
            r_pass      <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_prev      <= sort_data;
            r_sum_o     <= w_sum_o_nx;
            r_sum_s     <= w_sum_s_nx;
            r_xor_o     <= w_xor_o_nx;
            r_xor_s     <= w_xor_s_nx;
            r_err_order <= w_err_order_nx;
            // Only the first violation records its index.
            if (w_viol && !r_err_order) begin
              r_err_idx <= {1'b0, r_k};
            end
            if (w_last) begin
              // Counter holds at N-1 on the final beat so it never wraps.
              r_err_perm <= w_err_perm_nx;
              r_pass     <= !(w_err_order_nx | w_err_perm_nx);
              r_state    <= S_DONE;
            end else begin
              r_k <= r_k + 7'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign err_order = r_err_order;
  assign err_perm  = r_err_perm;
  assign err_idx   = r_err_idx;

endmodule

// File: tb/tb_sort_checker.sv
module tb_sort_checker;

  localparam int N = 100;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] orig_data;
  logic [W-1:0] sort_data;
  logic         done;
  logic         pass;
  logic         err_order;
  logic         err_perm;
  logic [7:0]   err_idx;

  logic [W-1:0] o_arr [N];
  logic [W-1:0] s_arr [N];

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  sort_checker #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .orig_data (orig_data),
    .sort_data (sort_data),
    .done      (done),
    .pass      (pass),
    .err_order (err_order),
    .err_perm  (err_perm),
    .err_idx   (err_idx)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one block from o_arr/s_arr. start_beat re-asserts start mid-block.
  task automatic run_block(input string nm, input bit toggle, input int start_beat,
                           input int exp_cyc, input bit exp_pass, input bit exp_ord,
                           input bit exp_perm, input int exp_idx);
    int  beat;
    int  cyc;
    bit  early;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    beat  = 0;
    cyc   = 1;
    early = 1'b0;
    chk({nm, ":ready_run"}, {63'd0, in_ready}, 64'd1);
    while (beat < N && cyc < 1000) begin
      in_valid = toggle ? cyc[0] : 1'b1;
      if (in_valid) begin
        orig_data = o_arr[beat];
        sort_data = s_arr[beat];
      end else begin
        orig_data = $urandom;
        sort_data = $urandom;
      end
      start = in_valid && (beat == start_beat);
      @(negedge clk);
      if (in_valid) beat++;
      cyc++;
      if (done && beat < N) early = 1'b1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({nm, ":early_done"}, {63'd0, early}, 64'd0);
    chk({nm, ":done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, ":done"}, {63'd0, done}, 64'd1);
    chk({nm, ":pass"}, {63'd0, pass}, {63'd0, exp_pass});
    chk({nm, ":err_order"}, {63'd0, err_order}, {63'd0, exp_ord});
    chk({nm, ":err_perm"}, {63'd0, err_perm}, {63'd0, exp_perm});
    chk({nm, ":err_idx"}, {56'd0, err_idx}, 64'(exp_idx));
    // start and in_valid during DONE must be ignored
    start     = 1'b1;
    in_valid  = 1'b1;
    orig_data = $urandom;
    sort_data = $urandom;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk({nm, ":done_pulse"}, {63'd0, done}, 64'd0);
    chk({nm, ":idle_ready"}, {63'd0, in_ready}, 64'd0);
    chk({nm, ":pass_held"}, {63'd0, pass}, {63'd0, exp_pass});
    chk({nm, ":order_held"}, {63'd0, err_order}, {63'd0, exp_ord});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    orig_data = '0;
    sort_data = '0;
    repeat (2) @(negedge clk);
    chk("rst:in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst:done", {63'd0, done}, 64'd0);
    chk("rst:pass", {63'd0, pass}, 64'd0);
    chk("rst:err_order", {63'd0, err_order}, 64'd0);
    chk("rst:err_perm", {63'd0, err_perm}, 64'd0);
    chk("rst:err_idx", {56'd0, err_idx}, 64'd0);
    rst_n = 1'b1;

    // in_valid in IDLE: no acceptance, no accumulator change
    in_valid = 1'b1;
    repeat (3) begin
      orig_data = $urandom;
      sort_data = $urandom;
      @(negedge clk);
      chk("idle:in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;

    // reversed source, ascending sorted
    for (int i = 0; i < N; i++) begin
      o_arr[i] = 32'(N - 1 - i);
      s_arr[i] = 32'(i);
    end
    run_block("rev", 1'b0, -1, 101, 1'b1, 1'b0, 1'b0, 0);

    // 40/41 swapped
    for (int i = 0; i < N; i++) begin
      o_arr[i] = 32'(i);
      s_arr[i] = 32'(i);
    end
    s_arr[40] = 32'd41;
    s_arr[41] = 32'd40;
    run_block("swap", 1'b0, -1, 101, 1'b0, 1'b1, 1'b0, 41);

    // last element 99 replaced by 100
    for (int i = 0; i < N; i++) begin
      o_arr[i] = 32'(i);
      s_arr[i] = 32'(i);
    end
    s_arr[99] = 32'd100;
    run_block("perm", 1'b0, -1, 101, 1'b0, 1'b0, 1'b1, 0);

    // all-ones, in_valid toggling; 100 accepted beats end at cycle 200
    for (int i = 0; i < N; i++) begin
      o_arr[i] = 32'hFFFF_FFFF;
      s_arr[i] = 32'hFFFF_FFFF;
    end
    run_block("ones", 1'b1, -1, 200, 1'b1, 1'b0, 1'b0, 0);

    // unsigned compare: 0x80000000 then 6 is a violation at 6; second at 71 not recorded
    for (int i = 0; i < N; i++) s_arr[i] = 32'(i);
    s_arr[5]  = 32'h8000_0000;
    s_arr[70] = 32'd71;
    s_arr[71] = 32'd70;
    for (int i = 0; i < N; i++) o_arr[i] = s_arr[N - 1 - i];
    run_block("unsgn", 1'b0, -1, 101, 1'b0, 1'b1, 1'b0, 6);

    // start during RUN at beat 10 is ignored
    for (int i = 0; i < N; i++) begin
      o_arr[i] = 32'(i * 3);
      s_arr[i] = 32'(i * 3);
    end
    run_block("restart", 1'b0, 10, 101, 1'b1, 1'b0, 1'b0, 0);

    // reset after beat 50 abandons the block; new start must be required
    for (int i = 0; i < N; i++) begin
      o_arr[i] = 32'(N - 1 - i);
      s_arr[i] = 32'(i);
    end
    s_arr[3] = 32'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0;
    for (int b = 0; b < 51; b++) begin
      in_valid  = 1'b1;
      orig_data = o_arr[b];
      sort_data = s_arr[b];
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort:err_order_pre", {63'd0, err_order}, 64'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    chk("abort:ready", {63'd0, in_ready}, 64'd0);
    chk("abort:err_order", {63'd0, err_order}, 64'd0);
    chk("abort:err_idx", {56'd0, err_idx}, 64'd0);
    repeat (5) begin
      @(negedge clk);
      if (done || in_ready) seen_done = 1'b1;
    end
    in_valid = 1'b0;
    chk("abort:no_done", {63'd0, seen_done}, 64'd0);
    s_arr[3] = 32'd3;
    run_block("after", 1'b0, -1, 101, 1'b1, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule

// File: doc/sort_checker.md
SORT_CHECKER -- requirements
Module: sort_checker

Interface
REQ-001 Parameter N, default 100: the number of elements in one sorted block.
REQ-002 Parameter W, default 32: the element width in bits; elements are unsigned.
REQ-003 clk input 1: the single clock; all state changes on the rising edge.
REQ-004 rst_n input 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start input 1: a one-cycle request to begin checking a new block; honoured only in IDLE.
REQ-006 in_valid input 1: the current beat carries one element pair.
REQ-007 in_ready output 1: the checker accepts a beat this cycle.
REQ-008 orig_data input W: unsorted source element k.
REQ-009 sort_data input W: element k of the block claimed to be sorted.
REQ-010 done output 1: a one-cycle pulse when the verdict is valid.
REQ-011 pass output 1: the verdict; 1 when no error was found. It is held until the next start.
REQ-012 err_order output 1: sticky; some sort_data[k] < sort_data[k-1].
REQ-013 err_perm output 1: the multiset checksums of the two streams differ.
REQ-014 err_idx output 8: the index k of the first ordering violation; 0 if there is none.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start.
- RUN -> DONE on the accepted beat with k == N-1.
- DONE -> IDLE after exactly one cycle.
REQ-016 in_ready SHALL be 1 only in RUN; a beat is accepted only when in_valid and in_ready are both 1.
REQ-017 A 7-bit beat counter k SHALL clear on start and increment by 1 per accepted beat; it SHALL not wrap within a block.
REQ-018 On each accepted beat with k > 0, if sort_data < prev, the block SHALL set err_order.
- prev is the registered sort_data of the previous accepted beat.
- On the first violation only, the block SHALL also load err_idx with k.
REQ-019 The block SHALL compare adjacent elements only when both were accepted in the same block; beat 0 SHALL never flag err_order.
REQ-020 Equal adjacent values SHALL be legal and SHALL NOT set err_order.
REQ-021 The block SHALL accumulate sum_o += orig_data and sum_s += sort_data, each W+7 bits wide, with no overflow for N ≤ 128.
REQ-022 The block SHALL accumulate xor_o ^= orig_data and xor_s ^= sort_data, each W bits wide.
REQ-023 Entering DONE, err_perm SHALL be set iff (sum_o != sum_s) or (xor_o != xor_s).
REQ-024 In the DONE cycle:
- done SHALL be 1.
- pass SHALL equal !(err_order | err_perm).
REQ-025 The verdict SHALL be available on the cycle after the last accepted beat; the block adds no further latency.
REQ-026 The block SHALL ignore start while in RUN or DONE.
REQ-027 The block SHALL ignore in_valid in IDLE and DONE; no accumulator changes.
REQ-028 A start in IDLE SHALL clear all of the following in the same edge:
- k, prev, all four accumulators;
- err_order, err_perm, err_idx, pass.
REQ-029 in_valid low in RUN SHALL stall the block with all state held; the block has no timeout.
REQ-030 The ordering comparison SHALL be unsigned, over the full W bits.

Reset
REQ-031 While rst_n is 0 at a clock edge, the block SHALL enter IDLE and zero every register.
- Outputs: in_ready = 0, done = 0, pass = 0, err_order = 0, err_perm = 0, err_idx = 0.
REQ-032 A reset asserted in RUN SHALL abandon the block with no done pulse; the next block requires a new start.
REQ-033 rst_n has priority over start and in_valid on the same edge.

Verification
REQ-034 Scenario: orig = 99..0, sort = 0..99, in_valid held 1 -> done occurs 101 cycles after start, pass = 1, err_order = 0, err_perm = 0.
REQ-035 Scenario: sort = 0..99 with positions 40 and 41 swapped (sort[40] = 41, sort[41] = 40) -> err_order = 1, err_idx = 41, err_perm = 0, pass = 0.
REQ-036 Scenario: orig = 0..99, sort = 0..98 followed by 100 -> err_perm = 1, err_order = 0, pass = 0.
REQ-037 Scenario: all elements 32'hFFFFFFFF in both streams, with in_valid toggling every other cycle -> pass = 1, and done occurs after exactly 100 accepted beats.
REQ-038 Scenario: rst_n pulsed low after beat 50, then a new start with a valid block -> no done for the aborted block; the second block gives pass = 1.
REQ-039 Scenario: start asserted during RUN at beat 10 -> ignored; the counter continues and the verdict is unaffected.
